// File: rtl/instr_fetch.sv
// instr_fetch: PC register, word-addressed instruction memory with a program-load
//   port, and the instruction register that feeds the control decoder.
// Latency: the word at the fetch PC reaches instr_o one edge after that PC is current.
//   The first valid_o comes on the 2nd edge after start_i. A taken redirect costs 1 bubble.
// Backpressure: stall_i=1 or ir_en_i=0 freezes PC, IR, pc_o and valid_o. The memory
//   read address is re-presented while frozen, so no fetched word is dropped.
//
// Ports:
//   clk_i, rst_ni                 clock (rising edge), synchronous active-low reset
//   iwr_en_i, iwr_addr_i,
//   iwr_data_i                    program-load write port, honoured only in LOAD
//   start_i                       leave LOAD and begin fetching at RESET_PC
//   stall_i, ir_en_i              hold controls (ir_en_i=0 acts as a stall)
//   be_i, br_taken_i, uje_i,
//   jalre_i, imm_i, rs1_val_i     redirect request for the instruction in IR
//   instr_o, pc_o, valid_o        instruction register, its PC, live flag
//   opcode_o, func3_o, func7_o    decode slices of instr_o
//   fault_o, state_o              sticky fetch fault; state LOAD=0 RUN=1 FLUSH=2 HALT=3
// Optional build macro IFETCH_PERF_CNT_EN adds fetch_cnt_o and redirect_cnt_o
//   (saturating 32-bit counters of IR loads and of taken redirects).

module instr_fetch #(
  parameter int               XLEN       = 32,
  parameter int               IMEM_DEPTH = 1024,
  parameter logic [XLEN-1:0]  RESET_PC   = '0
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          iwr_en_i,
  input  logic [$clog2(IMEM_DEPTH)-1:0] iwr_addr_i,
  input  logic [31:0]                   iwr_data_i,
  input  logic                          start_i,
  input  logic                          stall_i,
  input  logic                          ir_en_i,
  input  logic                          be_i,
  input  logic                          br_taken_i,
  input  logic                          uje_i,
  input  logic                          jalre_i,
  input  logic [XLEN-1:0]               imm_i,
  input  logic [XLEN-1:0]               rs1_val_i,
  output logic [31:0]                   instr_o,
  output logic [XLEN-1:0]               pc_o,
  output logic [6:0]                    opcode_o,
  output logic [2:0]                    func3_o,
  output logic [6:0]                    func7_o,
  output logic                          valid_o,
  output logic                          fault_o,
  output logic [1:0]                    state_o
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0]                   fetch_cnt_o,
  output logic [31:0]                   redirect_cnt_o
`endif
);

  localparam int AW = $clog2(IMEM_DEPTH);

  // Byte size of the memory, one bit wider than XLEN so that range checks are
  // done on the full XLEN-bit address before it is truncated to a word index.
  localparam logic [XLEN:0] MEM_BYTES = (XLEN+1)'(IMEM_DEPTH) << 2;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [XLEN-1:0] r_pc;          // fetch PC: address whose word sits in r_rdata
  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] r_pc_out;      // PC of the word held in r_ir
  logic [31:0]     r_ir;
  logic            r_valid;
  logic            w_valid_nxt;
  logic            r_fault;
  logic            w_fault_set;
  logic            w_ir_ld;

  logic [31:0]     r_mem [IMEM_DEPTH];
  logic [31:0]     r_rdata;
  logic [AW-1:0]   w_rd_addr;
  logic            w_mem_we;

  logic            w_advance;
  logic            w_redir_req;
  logic [XLEN-1:0] w_tgt_jalr;
  logic [XLEN-1:0] w_tgt_rel;
  logic [XLEN-1:0] w_target;
  logic            w_tgt_bad;
  logic            w_seq_oor;
  logic [XLEN-1:0] w_pc_inc;

  // --------------------------------------------------------------------------
  // Redirect and range evaluation
  // --------------------------------------------------------------------------
  assign w_advance = !stall_i && ir_en_i;

  // Only a live IR instruction may redirect; in FLUSH valid is already 0.
  assign w_redir_req = r_valid && (jalre_i || uje_i || (be_i && br_taken_i));

  assign w_tgt_jalr = (rs1_val_i + imm_i) & ~XLEN'(1);
  assign w_tgt_rel  = r_pc_out + imm_i;
  assign w_target   = jalre_i ? w_tgt_jalr : w_tgt_rel;

  assign w_tgt_bad  = (w_target[1:0] != 2'b00) || ({1'b0, w_target} >= MEM_BYTES);

  // The fetch PC only ever walks past the end sequentially (targets are
  // checked above), so testing it when we are about to consume it suffices.
  assign w_seq_oor  = ({1'b0, r_pc} >= MEM_BYTES);

  assign w_pc_inc   = r_pc + XLEN'(4);

  // --------------------------------------------------------------------------
  // Instruction memory: sync write, sync read of the *next* fetch PC so that
  // r_rdata always holds mem[r_pc] during the cycle r_pc is current.
  // --------------------------------------------------------------------------
  assign w_mem_we  = rst_ni && iwr_en_i && (r_state == ST_LOAD);
  assign w_rd_addr = w_pc_nxt[AW+1:2];

  always_ff @(posedge clk_i) begin
    if (w_mem_we) begin
      r_mem[iwr_addr_i] <= iwr_data_i;
    end
    // Write-first: a load on the same edge as start_i must be visible to
    // the first fetch.
    if (w_mem_we && (iwr_addr_i == w_rd_addr)) begin
      r_rdata <= iwr_data_i;
    end else begin
      r_rdata <= r_mem[w_rd_addr];
    end
  end

  // --------------------------------------------------------------------------
  // Fetch FSM: state and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state  <= ST_LOAD;
      r_pc     <= RESET_PC;
      r_pc_out <= RESET_PC;
      r_ir     <= NOP_INSTR;
      r_valid  <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_valid <= w_valid_nxt;
      if (w_fault_set) begin
        r_fault <= 1'b1;
      end
      if (w_ir_ld) begin
        r_ir     <= r_rdata;
        r_pc_out <= r_pc;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Fetch FSM: next state and datapath controls
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_valid_nxt = r_valid;
    w_ir_ld     = 1'b0;
    w_fault_set = 1'b0;

    case (r_state)
      ST_LOAD: begin
        if (start_i) begin
          w_state_nxt = ST_RUN;
          w_pc_nxt    = RESET_PC;
        end
      end

      ST_RUN: begin
        if (w_advance) begin
          if (w_redir_req) begin
            // The word in r_rdata is wrong-path; drop it and refetch.
            w_valid_nxt = 1'b0;
            if (w_tgt_bad) begin
              w_state_nxt = ST_HALT;
              w_fault_set = 1'b1;
            end else begin
              w_state_nxt = ST_FLUSH;
              w_pc_nxt    = w_target;
            end
          end else if (w_seq_oor) begin
            w_valid_nxt = 1'b0;
            w_state_nxt = ST_HALT;
            w_fault_set = 1'b1;
          end else begin
            w_ir_ld     = 1'b1;
            w_valid_nxt = 1'b1;
            w_pc_nxt    = w_pc_inc;
          end
        end
      end

      ST_FLUSH: begin
        // The target word was read on the redirect edge; the bubble cycle
        // ends by loading it into IR. Decoder enables are ignored here.
        if (w_advance) begin
          w_state_nxt = ST_RUN;
          w_ir_ld     = 1'b1;
          w_valid_nxt = 1'b1;
          w_pc_nxt    = w_pc_inc;
        end
      end

      ST_HALT: begin
        w_valid_nxt = 1'b0;
      end

      default: begin
        w_state_nxt = ST_LOAD;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign instr_o  = r_ir;
  assign pc_o     = r_pc_out;
  assign valid_o  = r_valid;
  assign fault_o  = r_fault;
  assign state_o  = r_state;
  assign opcode_o = r_ir[6:0];
  assign func3_o  = r_ir[14:12];
  assign func7_o  = r_ir[31:25];

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_redir_cnt;
  logic        w_redir_evt;

  // Counts only redirects that actually went to FLUSH, not faulting ones.
  assign w_redir_evt = (r_state == ST_RUN) && w_advance && w_redir_req && !w_tgt_bad;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_fetch_cnt <= '0;
      r_redir_cnt <= '0;
    end else begin
      if (w_ir_ld && (r_fetch_cnt != 32'hFFFF_FFFF)) begin
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
      if (w_redir_evt && (r_redir_cnt != 32'hFFFF_FFFF)) begin
        r_redir_cnt <= r_redir_cnt + 32'd1;
      end
    end
  end

  assign fetch_cnt_o    = r_fetch_cnt;
  assign redirect_cnt_o = r_redir_cnt;
`else
  // Performance counters not built.
`endif

endmodule
